// File: rtl/register_file_mp.sv
`default_nettype none
// ============================================================================
// Module  : register_file_mp
// Purpose : Dual-write, dual-read register file with bypass, optional zero
//           register and a sequential debug dump engine.
// Revision: 1.0
// ============================================================================
module register_file_mp #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int ZERO_REG = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   input  logic              reg_write_a,
   input  logic [ADDR_W-1:0] write_reg_a,
   input  logic [DATA_W-1:0] write_data_a,
   input  logic              reg_write_b,
   input  logic [ADDR_W-1:0] write_reg_b,
   input  logic [DATA_W-1:0] write_data_b,
   input  logic              dump_start,
   output logic              dump_busy,
   output logic              dump_valid,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [ADDR_W-1:0] c_LAST     = ADDR_W'(DEPTH - 1);
   localparam bit                c_HAS_ZERO = (ZERO_REG != 0);

   logic [DATA_W-1:0] mem_q [DEPTH];
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              wen_a, wen_b;

   assign wen_a = reg_write_a && !(c_HAS_ZERO && (write_reg_a == '0));
   assign wen_b = reg_write_b && !(c_HAS_ZERO && (write_reg_b == '0));

   // Port B is written last so a same-index collision resolves to the load.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (wen_a) mem_q[write_reg_a] <= write_data_a;
         if (wen_b) mem_q[write_reg_b] <= write_data_b;
      end
   end

   always_comb begin
      if (c_HAS_ZERO && (read_reg1 == '0))                read_data1 = '0;
      else if (reg_write_b && (write_reg_b == read_reg1)) read_data1 = write_data_b;
      else if (reg_write_a && (write_reg_a == read_reg1)) read_data1 = write_data_a;
      else                                                read_data1 = mem_q[read_reg1];
   end

   always_comb begin
      if (c_HAS_ZERO && (read_reg2 == '0))                read_data2 = '0;
      else if (reg_write_b && (write_reg_b == read_reg2)) read_data2 = write_data_b;
      else if (reg_write_a && (write_reg_a == read_reg2)) read_data2 = write_data_a;
      else                                                read_data2 = mem_q[read_reg2];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   // Dump outputs decode from state so reset drops them without a clock.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      dump_busy  = (state_q != S_IDLE);
      dump_valid = 1'b0;
      dump_addr  = '0;
      dump_data  = '0;
      case (state_q)
         S_IDLE: begin
            if (dump_start) begin
               state_d = S_RUN;
               ptr_d   = '0;
            end
         end
         S_RUN: begin
            dump_valid = 1'b1;
            dump_addr  = ptr_q;
            dump_data  = (c_HAS_ZERO && (ptr_q == '0)) ? '0 : mem_q[ptr_q];
            if (ptr_q == c_LAST) begin
               state_d = S_DONE;
               ptr_d   = '0;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_register_file_mp.sv
`default_nettype none
// ============================================================================
// Module  : tb_register_file_mp
// Purpose : Self-checking bench for register_file_mp (vector table + dump
//           scoreboard).
// Revision: 1.0
// ============================================================================
module tb_register_file_mp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  read_reg1, read_reg2;
   logic [31:0] read_data1, read_data2;
   logic        reg_write_a, reg_write_b;
   logic [4:0]  write_reg_a, write_reg_b;
   logic [31:0] write_data_a, write_data_b;
   logic        dump_start, dump_busy, dump_valid;
   logic [4:0]  dump_addr;
   logic [31:0] dump_data;

   int checks   = 0;
   int failures = 0;

   register_file_mp dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .read_reg1   (read_reg1),
      .read_reg2   (read_reg2),
      .read_data1  (read_data1),
      .read_data2  (read_data2),
      .reg_write_a (reg_write_a),
      .write_reg_a (write_reg_a),
      .write_data_a(write_data_a),
      .reg_write_b (reg_write_b),
      .write_reg_b (write_reg_b),
      .write_data_b(write_data_b),
      .dump_start  (dump_start),
      .dump_busy   (dump_busy),
      .dump_valid  (dump_valid),
      .dump_addr   (dump_addr),
      .dump_data   (dump_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wa;
      logic [4:0]  ia;
      logic [31:0] da;
      logic        wb;
      logic [4:0]  ib;
      logic [31:0] db;
      logic [4:0]  r1;
      logic [4:0]  r2;
      logic [31:0] e1;
      logic [31:0] e2;
   } vec_t;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } dump_t;

   vec_t        vecs [12];
   dump_t       sb [$];
   logic [31:0] model [32];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   task automatic write_a(input logic [4:0] idx, input logic [31:0] data);
      reg_write_a = 1'b1; write_reg_a = idx; write_data_a = data;
      @(posedge clk); #1;
      reg_write_a = 1'b0;
      if (idx != 5'd0) model[idx] = data;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_clear();
   endtask

   // Full dump: scoreboard loaded from the model when dump_start is driven.
   task automatic do_dump(input string tag);
      int n;
      dump_t exp;
      sb.delete();
      for (int i = 0; i < 32; i++) sb.push_back({5'(i), model[i]});
      dump_start = 1'b1;
      @(posedge clk); #1;
      dump_start = 1'b0;
      check({tag, "_busy_rise"}, 64'(dump_busy), 64'd1);
      n = 0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (!dump_valid) break;
         if (sb.size() == 0) begin
            check({tag, "_extra_beat"}, 64'(dump_addr), 64'hFFFF);
            break;
         end
         exp = sb.pop_front();
         check({tag, "_beat"}, {27'd0, dump_addr, dump_data}, {27'd0, exp.a, exp.d});
         n++;
         @(posedge clk); #1;
      end
      check({tag, "_beats"}, 64'(n), 64'd32);
      check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
      check({tag, "_done_cycle"}, {62'd0, dump_busy, dump_valid}, {62'd0, 1'b1, 1'b0});
      @(posedge clk); #2;
      check({tag, "_idle"}, {62'd0, dump_busy, dump_valid}, 64'd0);
   endtask

   initial begin
      bit found;
      rst_n = 1'b0;
      read_reg1 = '0; read_reg2 = '0;
      reg_write_a = 1'b0; write_reg_a = '0; write_data_a = '0;
      reg_write_b = 1'b0; write_reg_b = '0; write_data_b = '0;
      dump_start = 1'b0;
      model_clear();

      vecs[0]  = '{1'b1, 5'd1,  32'h0000FFFF, 1'b0, 5'd0,  32'h0,        5'd1,  5'd2,  32'h0000FFFF, 32'h0};
      vecs[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd1,  5'd2,  32'h0000FFFF, 32'h0};
      vecs[2]  = '{1'b1, 5'd30, 32'h11111111, 1'b1, 5'd30, 32'hFFFF0000, 5'd1,  5'd30, 32'h0000FFFF, 32'hFFFF0000};
      vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd30, 5'd30, 32'hFFFF0000, 32'hFFFF0000};
      vecs[4]  = '{1'b1, 5'd0,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,        5'd0,  5'd1,  32'h0,        32'h0000FFFF};
      vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'hDEADBEEF, 5'd0,  5'd0,  32'h0,        32'h0};
      vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd0,  5'd30, 32'h0,        32'hFFFF0000};
      vecs[7]  = '{1'b1, 5'd5,  32'h12345678, 1'b1, 5'd6,  32'h9ABCDEF0, 5'd5,  5'd6,  32'h12345678, 32'h9ABCDEF0};
      vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd6,  32'h12345678, 32'h9ABCDEF0};
      vecs[9]  = '{1'b1, 5'd5,  32'hAAAAAAAA, 1'b1, 5'd9,  32'h0F0F0F0F, 5'd5,  5'd9,  32'hAAAAAAAA, 32'h0F0F0F0F};
      vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        5'd5,  5'd9,  32'hAAAAAAAA, 32'h0F0F0F0F};
      vecs[11] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd0,  32'h00000001, 5'd31, 5'd0,  32'hCAFEF00D, 32'h0};

      // Reset state
      @(posedge clk); @(posedge clk); #2;
      read_reg1 = 5'd7; #1;
      check("rst_read", 64'(read_data1), 64'd0);
      check("rst_dump", {27'd0, dump_busy, dump_valid, dump_addr, dump_data[25:0]},
            64'd0);
      check("rst_dump_data", 64'(dump_data), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Reset clears stored contents
      write_a(5'd1, 32'h0000FFFF);
      read_reg1 = 5'd1; #1;
      check("pre_rst_r1", 64'(read_data1), 64'h0000FFFF);
      rst_n = 1'b0; #1;
      check("post_rst_r1", 64'(read_data1), 64'd0);
      check("post_rst_busy", 64'(dump_busy), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Vector table: pre-edge (bypass) reads, then commit at the edge
      foreach (vecs[i]) begin
         reg_write_a = vecs[i].wa; write_reg_a = vecs[i].ia; write_data_a = vecs[i].da;
         reg_write_b = vecs[i].wb; write_reg_b = vecs[i].ib; write_data_b = vecs[i].db;
         read_reg1 = vecs[i].r1; read_reg2 = vecs[i].r2;
         #1;
         check($sformatf("vec%0d_rd1", i), 64'(read_data1), 64'(vecs[i].e1));
         check($sformatf("vec%0d_rd2", i), 64'(read_data2), 64'(vecs[i].e2));
         @(posedge clk); #1;
      end
      reg_write_a = 1'b0; reg_write_b = 1'b0;

      // Full dump of a sparse preload
      pulse_reset();
      write_a(5'd1, 32'h0000FFFF);
      write_a(5'd30, 32'hFFFF0000);
      do_dump("dump1");

      // Second dump with every register populated
      for (int i = 0; i < 32; i++) write_a(5'(i), 32'h01000000 * i + 32'h00A5);
      do_dump("dump2");

      // Reset in the middle of a dump
      dump_start = 1'b1;
      @(posedge clk); #1;
      dump_start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         #1;
         if (dump_valid && dump_addr == 5'd10) begin
            found = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("abort_reached_addr10", 64'(found), 64'd1);
      rst_n = 1'b0; #1;
      check("abort_valid_busy", {62'd0, dump_valid, dump_busy}, 64'd0);
      check("abort_addr_data", {27'd0, dump_addr, dump_data}, 64'd0);
      read_reg1 = 5'd3; #1;
      check("abort_mem_clear", 64'(read_data1), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_clear();
      write_a(5'd3, 32'h33333333);
      do_dump("dump3");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
